// File: rtl/xy2_pkg.sv
// rtl/xy2_pkg.sv - XY2-100 frame constants, FSM state encoding and parity helper
package xy2_pkg;

    localparam int XY2_FRAME_BITS = 20;
    localparam int XY2_DATA_BITS  = 16;
    localparam int XY2_CTRL_BITS  = 3;
    localparam logic [XY2_CTRL_BITS-1:0] XY2_CTRL_POS = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        HUNT  = 2'd2,
        CHECK = 2'd3
    } xy2_state_e;

    // Returns 0 for a frame with even parity over all bits.
    function automatic logic xy2_parity(input logic [XY2_FRAME_BITS-1:0] frame);
        return ^frame;
    endfunction

endpackage

// File: rtl/xy2_rx_chan.sv
// rtl/xy2_rx_chan.sv - one XY2-100 channel: frame shift register with parity and control checks
module xy2_rx_chan
    import xy2_pkg::*;
#(
    parameter logic [XY2_CTRL_BITS-1:0] CTRL_EXP = XY2_CTRL_POS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift_en,
    input  logic                     clr,
    input  logic                     din,
    output logic [XY2_DATA_BITS-1:0] data,
    output logic                     par_ok,
    output logic                     ctrl_ok
);

    logic [XY2_FRAME_BITS-1:0] shreg_q;
    logic [XY2_FRAME_BITS-1:0] shreg_d;
    logic [XY2_FRAME_BITS-1:0] shreg_base;

    // clr together with shift_en starts a fresh frame with the incoming bit.
    always_comb begin
        shreg_base = clr ? '0 : shreg_q;
        shreg_d    = shreg_base;
        if (shift_en) begin
            shreg_d = {shreg_base[XY2_FRAME_BITS-2:0], din};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign data    = shreg_q[XY2_DATA_BITS:1];
    assign ctrl_ok = (shreg_q[XY2_FRAME_BITS-1 -: XY2_CTRL_BITS] == CTRL_EXP);
    assign par_ok  = ~xy2_parity(shreg_q);

endmodule

// File: rtl/xy2_100_rx.sv
// rtl/xy2_100_rx.sv - XY2-100 galvo-link receiver: synchronisers, sample detect, framing FSM
module xy2_100_rx
    import xy2_pkg::*;
#(
    parameter int                       SYNC_STAGES = 2,
    parameter int                       TIMEOUT_CYC = 64,
    parameter logic [XY2_CTRL_BITS-1:0] CTRL_EXP    = XY2_CTRL_POS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sendck,
    input  logic        sync,
    input  logic        chl_x,
    input  logic        chl_y,
    output logic [15:0] x_data,
    output logic [15:0] y_data,
    output logic        data_valid,
    output logic [1:0]  par_err,
    output logic [1:0]  ctrl_err,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0] LAST_BIT = 5'(XY2_FRAME_BITS - 1);

    // Per stage: {sendck, sync, chl_x, chl_y}
    logic [SYNC_STAGES-1:0][3:0] meta_q, meta_d;
    logic                        ck_prev_q, ck_prev_d;
    xy2_state_e                  state_q, state_d;
    logic [4:0]                  bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]               tmo_q, tmo_d;
    logic [15:0]                 x_data_q, x_data_d;
    logic [15:0]                 y_data_q, y_data_d;
    logic                        data_valid_q, data_valid_d;
    logic [1:0]                  par_err_q, par_err_d;
    logic [1:0]                  ctrl_err_q, ctrl_err_d;
    logic                        frame_err_q, frame_err_d;
    logic [15:0]                 frame_cnt_q, frame_cnt_d;

    logic        ck_cur, sync_s, x_s, y_s, smp;
    logic        shift_en, clr;
    logic [15:0] x_word, y_word;
    logic        x_par_ok, y_par_ok, x_ctrl_ok, y_ctrl_ok;

    assign ck_cur = meta_q[SYNC_STAGES-1][3];
    assign sync_s = meta_q[SYNC_STAGES-1][2];
    assign x_s    = meta_q[SYNC_STAGES-1][1];
    assign y_s    = meta_q[SYNC_STAGES-1][0];
    assign smp    = ck_prev_q & ~ck_cur;

    xy2_rx_chan #(.CTRL_EXP(CTRL_EXP)) u_chan_x (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .clr      (clr),
        .din      (x_s),
        .data     (x_word),
        .par_ok   (x_par_ok),
        .ctrl_ok  (x_ctrl_ok)
    );

    xy2_rx_chan #(.CTRL_EXP(CTRL_EXP)) u_chan_y (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .clr      (clr),
        .din      (y_s),
        .data     (y_word),
        .par_ok   (y_par_ok),
        .ctrl_ok  (y_ctrl_ok)
    );

    always_comb begin
        meta_d       = {meta_q[SYNC_STAGES-2:0], {sendck, sync, chl_x, chl_y}};
        ck_prev_d    = ck_cur;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_d        = '0;
        x_data_d     = x_data_q;
        y_data_d     = y_data_q;
        frame_cnt_d  = frame_cnt_q;
        data_valid_d = 1'b0;
        par_err_d    = 2'b00;
        ctrl_err_d   = 2'b00;
        frame_err_d  = 1'b0;
        shift_en     = 1'b0;
        clr          = 1'b0;

        case (state_q)
            IDLE: begin
                if (smp && sync_s) begin
                    shift_en  = 1'b1;
                    clr       = 1'b1;
                    bit_cnt_d = 5'd1;
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (smp) begin
                    if (sync_s && bit_cnt_q == LAST_BIT) begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end else if (sync_s) begin
                        shift_en  = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        shift_en = 1'b1;
                        state_d  = CHECK;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            HUNT: begin
                // Sync stuck high: wait for the low (parity) slot before re-arming.
                if (smp && !sync_s) begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (x_par_ok && y_par_ok && x_ctrl_ok && y_ctrl_ok) begin
                    x_data_d     = x_word;
                    y_data_d     = y_word;
                    data_valid_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                end else begin
                    par_err_d  = {~y_par_ok, ~x_par_ok};
                    ctrl_err_d = {~y_ctrl_ok, ~x_ctrl_ok};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q       <= '0;
            ck_prev_q    <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            x_data_q     <= '0;
            y_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 2'b00;
            ctrl_err_q   <= 2'b00;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            meta_q       <= meta_d;
            ck_prev_q    <= ck_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            x_data_q     <= x_data_d;
            y_data_q     <= y_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            ctrl_err_q   <= ctrl_err_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign x_data     = x_data_q;
    assign y_data     = y_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign ctrl_err   = ctrl_err_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_xy2_100_rx.sv
// tb/tb_xy2_100_rx.sv - scoreboard bench for the XY2-100 receiver driven by a 2 MHz link BFM
module tb_xy2_100_rx;

    logic        clk;
    logic        reset;
    logic        sendck;
    logic        sync;
    logic        chl_x;
    logic        chl_y;
    logic [15:0] x_data;
    logic [15:0] y_data;
    logic        data_valid;
    logic [1:0]  par_err;
    logic [1:0]  ctrl_err;
    logic        frame_err;
    logic [15:0] frame_cnt;

    xy2_100_rx #(
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (64),
        .CTRL_EXP    (3'b001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sendck     (sendck),
        .sync       (sync),
        .chl_x      (chl_x),
        .chl_y      (chl_y),
        .x_data     (x_data),
        .y_data     (y_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .ctrl_err   (ctrl_err),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    typedef struct {
        logic        dv;
        logic [1:0]  pe;
        logic [1:0]  ce;
        logic        fe;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] cnt;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    time         t_fall = 0;
    logic [15:0] m_x = 16'h0;
    logic [15:0] m_y = 16'h0;
    logic [15:0] m_cnt = 16'h0;

    // Latencies in ns from the pin falling edge to the sampling negedge:
    // 80 = CHECK result (4 posedges + half period), 60 = framing error on smp,
    // 1340 = smp processed at +50 then 64 cycles of timeout.
    localparam int LAT_DATA = 80;
    localparam int LAT_SMP  = 60;
    localparam int LAT_TMO  = 1340;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (data_valid || par_err != 2'b00 || ctrl_err != 2'b00 || frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output dv=%0b pe=%0b ce=%0b fe=%0b at %0t",
                         data_valid, par_err, ctrl_err, frame_err, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data_valid", 32'(data_valid), 32'(e.dv));
                chk("par_err",    32'(par_err),    32'(e.pe));
                chk("ctrl_err",   32'(ctrl_err),   32'(e.ce));
                chk("frame_err",  32'(frame_err),  32'(e.fe));
                chk("x_data",     32'(x_data),     32'(e.x));
                chk("y_data",     32'(y_data),     32'(e.y));
                chk("frame_cnt",  32'(frame_cnt),  32'(e.cnt));
                if (e.lat != 0) begin
                    chk("latency_ns", 32'($time - t_fall), 32'(e.lat));
                end
            end
        end
    end

    function automatic logic [19:0] mk(input logic [2:0] c, input logic [15:0] d, input logic flip);
        logic [19:0] f;
        f    = {c, d, 1'b0};
        f[0] = (^f) ^ flip;
        return f;
    endfunction

    task automatic push_ok(input logic [15:0] xv, input logic [15:0] yv);
        exp_t e;
        m_x   = xv;
        m_y   = yv;
        m_cnt = m_cnt + 16'd1;
        e = '{dv: 1'b1, pe: 2'b00, ce: 2'b00, fe: 1'b0, x: m_x, y: m_y, cnt: m_cnt, lat: LAT_DATA};
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] pe, input logic [1:0] ce, input logic fe, input int lat);
        exp_t e;
        e = '{dv: 1'b0, pe: pe, ce: ce, fe: fe, x: m_x, y: m_y, cnt: m_cnt, lat: lat};
        exp_q.push_back(e);
    endtask

    // 2 MHz bit: 240 ns high, 260 ns low keeps every pin edge on a clk negedge.
    task automatic send_bit(input logic s, input logic xb, input logic yb);
        sendck = 1'b1;
        sync   = s;
        chl_x  = xb;
        chl_y  = yb;
        #240;
        sendck = 1'b0;
        t_fall = $time;
        #260;
    endtask

    task automatic send_frame(input logic [19:0] fx, input logic [19:0] fy);
        for (int i = 19; i >= 0; i--) begin
            send_bit(i != 0, fx[i], fy[i]);
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_x_data"},     32'(x_data),     32'h0);
        chk({tag, "_y_data"},     32'(y_data),     32'h0);
        chk({tag, "_data_valid"}, 32'(data_valid), 32'h0);
        chk({tag, "_par_err"},    32'(par_err),    32'h0);
        chk({tag, "_ctrl_err"},   32'(ctrl_err),   32'h0);
        chk({tag, "_frame_err"},  32'(frame_err),  32'h0);
        chk({tag, "_frame_cnt"},  32'(frame_cnt),  32'h0);
    endtask

    initial begin
        logic [15:0] xv;
        logic [15:0] yv;

        reset  = 1'b1;
        sendck = 1'b0;
        sync   = 1'b0;
        chl_x  = 1'b0;
        chl_y  = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_cleared("reset");

        push_ok(16'h1234, 16'hABCD);
        send_frame(mk(3'b001, 16'h1234, 1'b0), mk(3'b001, 16'hABCD, 1'b0));

        for (int i = 0; i < 40; i++) begin
            xv = 16'($urandom);
            yv = 16'($urandom);
            push_ok(xv, yv);
            send_frame(mk(3'b001, xv, 1'b0), mk(3'b001, yv, 1'b0));
        end

        push_err(2'b10, 2'b00, 1'b0, LAT_DATA);
        send_frame(mk(3'b001, 16'h00FF, 1'b0), mk(3'b001, 16'h5A5A, 1'b1));

        push_err(2'b00, 2'b01, 1'b0, LAT_DATA);
        send_frame(mk(3'b000, 16'h4242, 1'b0), mk(3'b001, 16'h2424, 1'b0));
        push_ok(16'h8001, 16'h7FFE);
        send_frame(mk(3'b001, 16'h8001, 1'b0), mk(3'b001, 16'h7FFE, 1'b0));

        push_err(2'b00, 2'b00, 1'b1, LAT_SMP);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        push_ok(16'hC0DE, 16'hBEEF);
        send_frame(mk(3'b001, 16'hC0DE, 1'b0), mk(3'b001, 16'hBEEF, 1'b0));

        push_err(2'b00, 2'b00, 1'b1, LAT_SMP);
        for (int i = 0; i < 21; i++) send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        push_ok(16'h0001, 16'hFFFF);
        send_frame(mk(3'b001, 16'h0001, 1'b0), mk(3'b001, 16'hFFFF, 1'b0));

        push_err(2'b00, 2'b00, 1'b1, LAT_TMO);
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1, 1'b1);
        #1500;
        push_ok(16'h3C3C, 16'hC3C3);
        send_frame(mk(3'b001, 16'h3C3C, 1'b0), mk(3'b001, 16'hC3C3, 1'b0));

        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1, 1'b0);
        #105;
        reset = 1'b1;
        #1;
        check_cleared("async_reset");
        m_x   = 16'h0;
        m_y   = 16'h0;
        m_cnt = 16'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push_ok(16'h5555, 16'hAAAA);
        send_frame(mk(3'b001, 16'h5555, 1'b0), mk(3'b001, 16'hAAAA, 1'b0));

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
